// File: rtl/regwrite_seq_pkg.sv
// Shared encodings, state enum and write-back decode helpers for the
// register-file write-back sequencer.
package regwrite_seq_pkg;

  localparam int unsigned OP_W  = 3;
  localparam int unsigned REG_W = 5;
  localparam int unsigned SEL_W = 2;

  localparam logic [OP_W-1:0] OP_NOP   = 3'b000;
  localparam logic [OP_W-1:0] OP_RTYPE = 3'b001;
  localparam logic [OP_W-1:0] OP_IMM   = 3'b010;
  localparam logic [OP_W-1:0] OP_LOAD  = 3'b011;
  localparam logic [OP_W-1:0] OP_JAL   = 3'b100;
  localparam logic [OP_W-1:0] OP_PUSH  = 3'b101;
  localparam logic [OP_W-1:0] OP_POP   = 3'b110;
  localparam logic [OP_W-1:0] OP_RSV   = 3'b111;

  localparam logic [SEL_W-1:0] SEL_RD = 2'b00;
  localparam logic [SEL_W-1:0] SEL_RT = 2'b01;
  localparam logic [SEL_W-1:0] SEL_RA = 2'b10;
  localparam logic [SEL_W-1:0] SEL_SP = 2'b11;

  localparam logic [SEL_W-1:0] DAT_ALU = 2'b00;
  localparam logic [SEL_W-1:0] DAT_MEM = 2'b01;
  localparam logic [SEL_W-1:0] DAT_PC  = 2'b10;

  localparam logic [REG_W-1:0] REG_RA = 5'd31;
  localparam logic [REG_W-1:0] REG_SP = 5'd29;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_MEM,
    ST_WB1,
    ST_WB2,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [SEL_W-1:0] wreg_sel;
    logic [SEL_W-1:0] wdata_sel;
  } wb_sel_t;

  // Destination/data selects for a WB state; second is set only in WB2 of POP.
  function automatic wb_sel_t wb_decode(input logic [OP_W-1:0] op, input logic second);
    wb_sel_t s;
    s.wreg_sel  = SEL_RD;
    s.wdata_sel = DAT_ALU;
    case (op)
      OP_IMM:  s.wreg_sel = SEL_RT;
      OP_LOAD: begin s.wreg_sel = SEL_RT; s.wdata_sel = DAT_MEM; end
      OP_JAL:  begin s.wreg_sel = SEL_RA; s.wdata_sel = DAT_PC;  end
      OP_PUSH: s.wreg_sel = SEL_SP;
      OP_POP:  begin
        s.wreg_sel  = second ? SEL_SP  : SEL_RT;
        s.wdata_sel = second ? DAT_ALU : DAT_MEM;
      end
      default: ;
    endcase
    return s;
  endfunction

  function automatic logic [REG_W-1:0] dest_reg(input logic [SEL_W-1:0] sel,
                                                input logic [REG_W-1:0] rd,
                                                input logic [REG_W-1:0] rt);
    case (sel)
      SEL_RD:  return rd;
      SEL_RT:  return rt;
      SEL_RA:  return REG_RA;
      default: return REG_SP;
    endcase
  endfunction

endpackage

// File: rtl/regwrite_seq_if.sv
// Control-FSM side request and register-bank side write-back controls.
interface regwrite_seq_if;
  import regwrite_seq_pkg::*;

  logic             start;
  logic [OP_W-1:0]  op;
  logic [REG_W-1:0] rd;
  logic [REG_W-1:0] rt;
  logic             mem_ready;
  logic [SEL_W-1:0] wreg_sel;
  logic [SEL_W-1:0] wdata_sel;
  logic             reg_write;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, op, rd, rt, mem_ready,
    input  wreg_sel, wdata_sel, reg_write, busy, done, err
  );

  modport slave (
    input  start, op, rd, rt, mem_ready,
    output wreg_sel, wdata_sel, reg_write, busy, done, err
  );
endinterface

// File: rtl/regwrite_seq_mem_wait_timer.sv
// Counts WAIT_MEM cycles without mem_ready; flags the last allowed cycle.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic mem_ready,
  output logic timeout_c
);
  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (enable && !mem_ready) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // mem_ready on the final cycle suppresses the timeout.
  assign timeout_c = enable && !mem_ready && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));
endmodule

// File: rtl/regwrite_seq.sv
// Write-back sequencer: drives register-file write select, data select and
// write enable for one instruction class per start.
module regwrite_seq
  import regwrite_seq_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  regwrite_seq_if.slave bus
);

  state_e           state_q, state_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [REG_W-1:0] rd_q, rd_d, rt_q, rt_d;
  wb_sel_t          sel_q, sel_d;
  logic             we_q, we_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic             timeout_c;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clear     (state_q != ST_WAIT_MEM),
    .enable    (state_q == ST_WAIT_MEM),
    .mem_ready (bus.mem_ready),
    .timeout_c (timeout_c)
  );

  // Next state plus outputs decoded from the next state so they register in step.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    rt_d    = rt_q;
    err_d   = 1'b0;
    sel_d   = '0;
    we_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          op_d = bus.op;
          rd_d = bus.rd;
          rt_d = bus.rt;
          case (bus.op)
            OP_RTYPE, OP_IMM, OP_JAL: state_d = ST_WB1;
            OP_LOAD, OP_PUSH, OP_POP: state_d = ST_WAIT_MEM;
            default: begin
              state_d = ST_DONE;
              err_d   = (bus.op == OP_RSV);
            end
          endcase
        end
      end
      ST_WAIT_MEM: begin
        if (bus.mem_ready) begin
          state_d = ST_WB1;
        end else if (timeout_c) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end
      end
      ST_WB1:  state_d = (op_q == OP_POP) ? ST_WB2 : ST_DONE;
      ST_WB2:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Writes to $0 via rd/rt keep the selects but drop the enable.
    if (state_d == ST_WB1 || state_d == ST_WB2) begin
      sel_d = wb_decode(op_d, state_d == ST_WB2);
      we_d  = (dest_reg(sel_d.wreg_sel, rd_d, rt_d) != '0);
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      rt_q    <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rt_q    <= rt_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.wreg_sel  = sel_q.wreg_sel;
  assign bus.wdata_sel = sel_q.wdata_sel;
  assign bus.reg_write = we_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_regwrite_seq.sv
// Randomised bench for regwrite_seq against a per-transaction cycle-trace model.
module tb_regwrite_seq;
  localparam int unsigned TMO = 4;

  typedef struct packed {
    logic [1:0] wreg;
    logic [1:0] wdata;
    logic       we;
    logic       busy;
    logic       done;
    logic       err;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  regwrite_seq_if bus ();

  regwrite_seq #(.MEM_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  obs_t exp_q[$];
  int   widx_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic obs_t observe();
    obs_t o;
    o.wreg  = bus.wreg_sel;
    o.wdata = bus.wdata_sel;
    o.we    = bus.reg_write;
    o.busy  = bus.busy;
    o.done  = bus.done;
    o.err   = bus.err;
    return o;
  endfunction

  // One write-back cycle straight from the op table.
  task automatic push_wb(input logic [2:0] op, input bit second,
                         input logic [4:0] rd, input logic [4:0] rt);
    obs_t e;
    e = '0;
    e.busy = 1'b1;
    case (op)
      3'b001: begin e.wreg = 2'd0; e.wdata = 2'd0; e.we = (rd != 5'd0); end
      3'b010: begin e.wreg = 2'd1; e.wdata = 2'd0; e.we = (rt != 5'd0); end
      3'b011: begin e.wreg = 2'd1; e.wdata = 2'd1; e.we = (rt != 5'd0); end
      3'b100: begin e.wreg = 2'd2; e.wdata = 2'd2; e.we = 1'b1; end
      3'b101: begin e.wreg = 2'd3; e.wdata = 2'd0; e.we = 1'b1; end
      default: begin
        if (second) begin e.wreg = 2'd3; e.wdata = 2'd0; e.we = 1'b1; end
        else        begin e.wreg = 2'd1; e.wdata = 2'd1; e.we = (rt != 5'd0); end
      end
    endcase
    exp_q.push_back(e);
    widx_q.push_back(-1);
  endtask

  // d = number of low mem_ready cycles before it rises; d >= TMO means never.
  task automatic build(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rt,
                       input int d);
    obs_t e;
    bit is_mem, is_wb, tmo;
    int nwait;
    exp_q.delete();
    widx_q.delete();
    is_mem = (op == 3'b011) || (op == 3'b101) || (op == 3'b110);
    is_wb  = (op == 3'b001) || (op == 3'b010) || (op == 3'b100);
    tmo    = is_mem && (d >= int'(TMO));
    if (is_wb) push_wb(op, 1'b0, rd, rt);
    if (is_mem) begin
      nwait = tmo ? int'(TMO) : d + 1;
      for (int j = 0; j < nwait; j++) begin
        e = '0;
        e.busy = 1'b1;
        exp_q.push_back(e);
        widx_q.push_back(j);
      end
      if (!tmo) begin
        push_wb(op, 1'b0, rd, rt);
        if (op == 3'b110) push_wb(op, 1'b1, rd, rt);
      end
    end
    e = '0;
    e.busy = 1'b1;
    e.done = 1'b1;
    e.err  = (op == 3'b111) || tmo;
    exp_q.push_back(e);
    widx_q.push_back(-1);
  endtask

  // Entered and left #1 after a rising edge with the DUT idle.
  task automatic run_txn(input string name, input logic [2:0] op, input logic [4:0] rd,
                         input logic [4:0] rt, input int d);
    build(op, rd, rt, d);
    bus.start     = 1'b1;
    bus.op        = op;
    bus.rd        = rd;
    bus.rt        = rt;
    bus.mem_ready = 1'($urandom);
    @(negedge clk);
    check({name, " idle"}, 32'(observe()), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < exp_q.size(); i++) begin
      bus.start     = 1'($urandom);
      bus.op        = 3'($urandom);
      bus.rd        = 5'($urandom);
      bus.rt        = 5'($urandom);
      bus.mem_ready = (widx_q[i] >= 0) ? (widx_q[i] == d) : 1'($urandom);
      @(negedge clk);
      check($sformatf("%s c%0d", name, i), 32'(observe()), 32'(exp_q[i]));
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
  endtask

  function automatic logic [4:0] rnd_reg();
    return ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.op = '0; bus.rd = '0; bus.rt = '0; bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset", 32'(observe()), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    run_txn("rtype_rd5",   3'b001, 5'd5, 5'd9, 0);
    run_txn("pop_rt8",     3'b110, 5'd3, 5'd8, 2);
    run_txn("imm_rt0",     3'b010, 5'd7, 5'd0, 0);
    run_txn("jal",         3'b100, 5'd0, 5'd0, 0);
    run_txn("load_tmo",    3'b011, 5'd1, 5'd4, 99);
    run_txn("load_last",   3'b011, 5'd1, 5'd4, int'(TMO) - 1);
    run_txn("load_first",  3'b011, 5'd1, 5'd6, 0);
    run_txn("rsv",         3'b111, 5'd2, 5'd2, 0);
    run_txn("nop",         3'b000, 5'd2, 5'd2, 0);
    run_txn("push_busy",   3'b101, 5'd0, 5'd0, 1);
    run_txn("pop_rt0",     3'b110, 5'd3, 5'd0, 0);

    // Reset in WB1 of POP: no WB2 and no done afterwards.
    bus.start = 1'b1; bus.op = 3'b110; bus.rd = 5'd1; bus.rt = 5'd8; bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.mem_ready = 1'b1;
    @(negedge clk);
    check("rstpop wait", 32'(observe()), 32'h04);
    @(posedge clk); #1;
    @(negedge clk);
    check("rstpop wb1", 32'(observe()), 32'h5c);
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rstpop rst", 32'(observe()), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rstpop after", 32'(observe()), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rstpop nodone", 32'(observe()), 32'd0);
    @(posedge clk); #1;

    for (int k = 0; k < 80; k++) begin
      run_txn($sformatf("rnd%0d", k), 3'($urandom), rnd_reg(), rnd_reg(),
              int'($urandom_range(0, 6)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
